// File: rtl/nand_bist_pkg.sv
// Shared types and helpers for the NAND array self-test harness: FSM state
// encoding, the golden NAND reference and a saturating accumulator step.
package nand_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // NAND of the low n_in bits of pat; higher bits are ignored.
  function automatic logic golden_nand(input logic [7:0] pat, input int n_in);
    logic [7:0] mask;
    mask = 8'((9'd1 << n_in) - 9'd1);
    return !((pat & mask) == mask);
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] acc,
                                          input logic [4:0]  inc,
                                          input logic [15:0] max_v);
    logic [16:0] sum;
    sum = {1'b0, acc} + {12'd0, inc};
    return (sum > {1'b0, max_v}) ? max_v : sum[15:0];
  endfunction

endpackage

// File: rtl/nand_bist_if.sv
// Stimulus/result bundle between a test controller (master) and the BIST core (slave).
interface nand_bist_if #(
  parameter int N_IN  = 2,
  parameter int CH    = 4,
  parameter int ERR_W = 8
);
  logic             start;
  logic             ext_mode;
  logic [CH-1:0]    flt_en;
  logic [CH-1:0]    ext_resp;
  logic [N_IN-1:0]  pat_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [N_IN-1:0]  fail_pat;
  logic [CH-1:0]    fail_ch;

  modport master (
    output start, ext_mode, flt_en, ext_resp,
    input  pat_out, busy, done, pass, err_cnt, fail_pat, fail_ch
  );

  modport slave (
    input  start, ext_mode, flt_en, ext_resp,
    output pat_out, busy, done, pass, err_cnt, fail_pat, fail_ch
  );
endinterface

// File: rtl/nand_array.sv
// CH-channel N_IN-input NAND array with stuck-at-1 fault injection and a
// LAT-deep registered output pipeline.
module nand_array
  import nand_bist_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int CH   = 4,
  parameter int LAT  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] pat,
  input  logic [CH-1:0]   flt_en,
  output logic [CH-1:0]   resp
);

  logic [CH-1:0] pipe_q [LAT];
  logic [CH-1:0] pipe_d [LAT];

  always_comb begin
    pipe_d[0] = {CH{golden_nand(8'(pat), N_IN)}} | flt_en;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '{default: '0};
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign resp = pipe_q[LAT-1];

endmodule

// File: rtl/nand_bist.sv
// Sweeps every input pattern through the NAND array (or external cells),
// compares each channel to the golden NAND and reports count/first failure.
module nand_bist
  import nand_bist_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int CH    = 4,
  parameter int LAT   = 2,
  parameter int ERR_W = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  nand_bist_if.slave bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_DRIVE = DRIVE;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;

  localparam int              CNT_W   = $clog2(LAT + 1);
  localparam logic [N_IN-1:0] PAT_MAX = '1;
  localparam logic [15:0]     ERR_MAX = 16'((32'd1 << ERR_W) - 32'd1);

  logic [1:0]       state_q, state_d;
  logic [N_IN-1:0]  pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ext_q, ext_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  logic [N_IN-1:0]  fp_q, fp_d;
  logic [CH-1:0]    fc_q, fc_d;
  logic             ff_q, ff_d;

  // Expected-response shift register: valid, pattern and golden bit per stage.
  logic             vld_q [LAT];
  logic             vld_d [LAT];
  logic [N_IN-1:0]  xpat_q [LAT];
  logic [N_IN-1:0]  xpat_d [LAT];
  logic             gold_q [LAT];
  logic             gold_d [LAT];

  logic [CH-1:0]    arr_resp;
  logic [CH-1:0]    resp;
  logic [CH-1:0]    mismatch;
  logic [4:0]       pop;

  nand_array #(.N_IN(N_IN), .CH(CH), .LAT(LAT)) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .pat    (pat_q),
    .flt_en (bus.flt_en),
    .resp   (arr_resp)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    ext_d   = ext_q;
    err_d   = err_q;
    pass_d  = pass_q;
    fp_d    = fp_q;
    fc_d    = fc_q;
    ff_d    = ff_q;

    vld_d[0]  = (state_q == S_DRIVE);
    xpat_d[0] = pat_q;
    gold_d[0] = golden_nand(8'(pat_q), N_IN);
    for (int i = 1; i < LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      xpat_d[i] = xpat_q[i-1];
      gold_d[i] = gold_q[i-1];
    end

    resp     = ext_q ? bus.ext_resp : arr_resp;
    mismatch = resp ^ {CH{gold_q[LAT-1]}};
    pop      = '0;
    for (int c = 0; c < CH; c++) begin
      pop = pop + 5'(mismatch[c]);
    end

    if (vld_q[LAT-1]) begin
      err_d = ERR_W'(sat_add(16'(err_q), pop, ERR_MAX));
      if ((mismatch != '0) && !ff_q) begin
        ff_d = 1'b1;
        fp_d = xpat_q[LAT-1];
        fc_d = mismatch;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_DRIVE;
          pat_d   = '0;
          ext_d   = bus.ext_mode;
          err_d   = '0;
          pass_d  = 1'b0;
          fp_d    = '0;
          fc_d    = '0;
          ff_d    = 1'b0;
        end
      end
      S_DRIVE: begin
        if (pat_q == PAT_MAX) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_W'(LAT);
        end else begin
          pat_d = pat_q + 1'b1;
        end
      end
      default: begin
        // Final accumulation lands on the edge before this exit, so err_q is complete.
        if (cnt_q == '0) begin
          state_d = S_DONE;
          pass_d  = (err_q == '0);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
      ext_q   <= 1'b0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      fp_q    <= '0;
      fc_q    <= '0;
      ff_q    <= 1'b0;
      vld_q   <= '{default: 1'b0};
      xpat_q  <= '{default: '0};
      gold_q  <= '{default: 1'b0};
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      ext_q   <= ext_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      fp_q    <= fp_d;
      fc_q    <= fc_d;
      ff_q    <= ff_d;
      vld_q   <= vld_d;
      xpat_q  <= xpat_d;
      gold_q  <= gold_d;
    end
  end

  assign bus.pat_out  = pat_q;
  assign bus.busy     = (state_q == S_DRIVE) || (state_q == S_DRAIN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.pass     = pass_q;
  assign bus.err_cnt  = err_q;
  assign bus.fail_pat = fp_q;
  assign bus.fail_ch  = fc_q;

endmodule

// File: tb/tb_nand_bist.sv
// Randomised scoreboard bench for nand_bist: a small (2-input) and a wider
// (4-input, 4-bit counter) instance checked against a per-sweep result model.
module tb_nand_bist;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef logic [3:0] tbl_t [16];
  typedef struct {
    int err;
    int pass;
    int fp;
    int fc;
    int scyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  tbl_t tbl_a;
  tbl_t tbl_b;
  int   launch_a = -100;
  int   launch_b = -100;

  nand_bist_if #(.N_IN(2), .CH(4), .ERR_W(8)) ifa ();
  nand_bist_if #(.N_IN(4), .CH(4), .ERR_W(4)) ifb ();

  nand_bist #(.N_IN(2), .CH(4), .LAT(LAT), .ERR_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  nand_bist #(.N_IN(4), .CH(4), .LAT(LAT), .ERR_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sweep outcome from the rules: golden output is 1 except at all-ones.
  function automatic exp_t model(input int n, input int errw, input bit ext,
                                 input logic [3:0] flt, input tbl_t tbl, input int scyc);
    exp_t e;
    int cnt;
    int maxv;
    bit found;
    logic [3:0] g;
    logic [3:0] mm;
    cnt = 0; found = 0; maxv = (1 << errw) - 1;
    e.fp = 0; e.fc = 0; e.scyc = scyc;
    for (int p = 0; p < (1 << n); p++) begin
      g  = (p == (1 << n) - 1) ? 4'b0000 : 4'b1111;
      mm = (ext ? tbl[p] : (g | flt)) ^ g;
      cnt = cnt + $countones(mm);
      if (cnt > maxv) cnt = maxv;
      if (mm != 4'b0000 && !found) begin
        found = 1; e.fp = p; e.fc = int'(mm);
      end
    end
    e.err = cnt;
    e.pass = (cnt == 0) ? 1 : 0;
    return e;
  endfunction

  // External responses: pattern p's response appears LAT cycles after p is driven.
  initial begin
    int p;
    ifa.ext_resp = '0;
    forever begin
      @(negedge clk);
      p = cyc - launch_a - LAT;
      if (p >= 0 && p < 4) ifa.ext_resp = tbl_a[p];
      else                 ifa.ext_resp = 4'($urandom);
    end
  end

  initial begin
    int p;
    ifb.ext_resp = '0;
    forever begin
      @(negedge clk);
      p = cyc - launch_b - LAT;
      if (p >= 0 && p < 16) ifb.ext_resp = tbl_b[p];
      else                  ifb.ext_resp = 4'($urandom);
    end
  end

  // Monitors: on each rising done, pop and compare the oldest expectation.
  initial begin
    bit pd;
    exp_t e;
    pd = 0;
    forever begin
      @(negedge clk);
      if (ifa.done && !pd) begin
        if (qa.size() == 0) check("a_unexpected_done", 1, 0);
        else begin
          e = qa.pop_front();
          check("a_err_cnt", int'(ifa.err_cnt), e.err);
          check("a_pass", int'(ifa.pass), e.pass);
          check("a_fail_pat", int'(ifa.fail_pat), e.fp);
          check("a_fail_ch", int'(ifa.fail_ch), e.fc);
          check("a_latency", cyc - e.scyc, 4 + LAT + 1);
        end
      end
      pd = ifa.done;
    end
  end

  initial begin
    bit pd;
    exp_t e;
    pd = 0;
    forever begin
      @(negedge clk);
      if (ifb.done && !pd) begin
        if (qb.size() == 0) check("b_unexpected_done", 1, 0);
        else begin
          e = qb.pop_front();
          check("b_err_cnt", int'(ifb.err_cnt), e.err);
          check("b_pass", int'(ifb.pass), e.pass);
          check("b_fail_pat", int'(ifb.fail_pat), e.fp);
          check("b_fail_ch", int'(ifb.fail_ch), e.fc);
          check("b_latency", cyc - e.scyc, 16 + LAT + 1);
        end
      end
      pd = ifb.done;
    end
  end

  task automatic launch_a_sweep(input bit ext, input logic [3:0] flt, input bit hold);
    @(negedge clk);
    ifa.start = 1'b1; ifa.ext_mode = ext; ifa.flt_en = flt;
    launch_a = cyc + 1;
    qa.push_back(model(2, 8, ext, flt, tbl_a, cyc + 1));
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      if (p == 0) begin
        if (!hold) ifa.start = 1'b0;
        check("a_launch_done_clr", int'(ifa.done), 0);
        check("a_launch_err_clr", int'(ifa.err_cnt), 0);
      end
      check("a_pat_out", int'(ifa.pat_out), p);
      check("a_busy", int'(ifa.busy), 1);
    end
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (!ifa.done && n < 50) begin @(negedge clk); n++; end
    check("a_done_timeout", int'(ifa.done), 1);
  endtask

  task automatic launch_b_sweep(input bit ext, input logic [3:0] flt);
    int n = 0;
    @(negedge clk);
    ifb.start = 1'b1; ifb.ext_mode = ext; ifb.flt_en = flt;
    launch_b = cyc + 1;
    qb.push_back(model(4, 4, ext, flt, tbl_b, cyc + 1));
    @(negedge clk);
    ifb.start = 1'b0;
    while (!ifb.done && n < 60) begin @(negedge clk); n++; end
    check("b_done_timeout", int'(ifb.done), 1);
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_pat_out"}, int'(ifa.pat_out), 0);
    check({tag, "_busy"}, int'(ifa.busy), 0);
    check({tag, "_done"}, int'(ifa.done), 0);
    check({tag, "_pass"}, int'(ifa.pass), 0);
    check({tag, "_err_cnt"}, int'(ifa.err_cnt), 0);
    check({tag, "_fail_pat"}, int'(ifa.fail_pat), 0);
    check({tag, "_fail_ch"}, int'(ifa.fail_ch), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    ifa.start = 1'b0; ifa.ext_mode = 1'b0; ifa.flt_en = '0;
    ifb.start = 1'b0; ifb.ext_mode = 1'b0; ifb.flt_en = '0;
    for (int i = 0; i < 16; i++) begin tbl_a[i] = '0; tbl_b[i] = '0; end
    repeat (2) @(negedge clk);
    check_a_zero("rst");
    check("rst_b_err_cnt", int'(ifb.err_cnt), 0);
    rst_n = 1'b1;

    // Directed sweeps on the 2-input instance.
    launch_a_sweep(1'b0, 4'b0000, 1'b0); wait_done_a();
    launch_a_sweep(1'b0, 4'b0010, 1'b0); wait_done_a();
    launch_a_sweep(1'b0, 4'b1111, 1'b0); wait_done_a();
    launch_a_sweep(1'b1, 4'b0000, 1'b0); wait_done_a();

    // Reset in the middle of a sweep.
    @(negedge clk);
    ifa.start = 1'b1; ifa.ext_mode = 1'b0; ifa.flt_en = 4'b0101;
    @(negedge clk);
    ifa.start = 1'b0;
    n = 0;
    while (ifa.pat_out != 2'd2 && n < 10) begin @(negedge clk); n++; end
    check("a_reach_pat2", int'(ifa.pat_out), 2);
    #2 rst_n = 1'b0;
    #1 check_a_zero("midrst");
    qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    launch_a_sweep(1'b0, 4'b0000, 1'b0); wait_done_a();

    // Start held high: no restart while busy, relaunch from DONE.
    launch_a_sweep(1'b0, 4'b1000, 1'b1); wait_done_a();
    @(negedge clk);
    check("a_relaunch_busy", int'(ifa.busy), 1);
    check("a_relaunch_done", int'(ifa.done), 0);
    check("a_relaunch_pass", int'(ifa.pass), 0);
    check("a_relaunch_err", int'(ifa.err_cnt), 0);
    check("a_relaunch_pat", int'(ifa.pat_out), 0);
    launch_a = cyc;
    qa.push_back(model(2, 8, 1'b0, 4'b1000, tbl_a, cyc));
    ifa.start = 1'b0;
    wait_done_a();

    // Randomised sweeps on the 2-input instance.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++) tbl_a[i] = 4'($urandom);
      launch_a_sweep(1'($urandom_range(0, 1)), 4'($urandom), 1'b0);
      wait_done_a();
    end

    // Wide instance: external stuck-at-0 saturates the 4-bit counter.
    launch_b_sweep(1'b1, 4'b0000);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) tbl_b[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      tbl_b[15] = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
      launch_b_sweep(1'($urandom_range(0, 1)), 4'($urandom));
    end

    repeat (3) @(negedge clk);
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
